// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter in front of a single-port data
// memory with registered read latency. Each granted access takes one ISSUE
// cycle plus READ_LATENCY WAIT cycles; the completion pulse lands in the
// following cycle, which doubles as the next arbitration cycle.
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | arbitrate between unmasked requests; memory bus holds last values
//   ISSUE | memory captures address (and data when mem_wren_o is high)
//   WAIT  | count down the memory read latency; complete on count == 1
module dmem_arbiter #(
  parameter int DATA_WIDTH   = 12,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  wr0_i,
  input  logic                  wr1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  output logic                  ack0_o,
  output logic                  ack1_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  mem_wren_o,
  input  logic [DATA_WIDTH-1:0] mem_q_i,
  output logic                  busy_o,
  output logic                  owner_o
);

  localparam int CW = 3;
  localparam logic [CW-1:0] LAT = CW'(READ_LATENCY);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           cnt_q;
  logic                    last_grant_q;
  logic                    owner_q;
  logic                    wr_q;
  logic                    ack0_q;
  logic                    ack1_q;
  logic                    mem_wren_q;
  logic                    busy_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_data_q;
  logic [DATA_WIDTH-1:0]   rdata0_q;
  logic [DATA_WIDTH-1:0]   rdata1_q;

  logic                    elig0;
  logic                    elig1;
  logic                    grant_d;
  logic                    win_d;
  logic                    win_wr_d;
  logic [ADDR_WIDTH-1:0]   win_addr_d;
  logic [DATA_WIDTH-1:0]   win_data_d;

  // Round-robin pick; a port still showing its ack is finishing, not asking again
  always_comb begin
    elig0      = req0_i & ~ack0_q;
    elig1      = req1_i & ~ack1_q;
    grant_d    = elig0 | elig1;
    if (elig0 && elig1) begin
      win_d = ~last_grant_q;
    end else begin
      win_d = elig1;
    end
    win_wr_d   = win_d ? wr1_i    : wr0_i;
    win_addr_d = win_d ? addr1_i  : addr0_i;
    win_data_d = win_d ? wdata1_i : wdata0_i;
  end

  // Sequencer: grant, drive the memory for one cycle, wait out the latency, complete
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      wr_q         <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      mem_wren_q   <= 1'b0;
      busy_q       <= 1'b0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q      <= ISSUE;
            owner_q      <= win_d;
            last_grant_q <= win_d;
            wr_q         <= win_wr_d;
            mem_wren_q   <= win_wr_d;
            mem_addr_q   <= win_addr_d;
            mem_data_q   <= win_data_d;
            busy_q       <= 1'b1;
          end
        end
        ISSUE: begin
          mem_wren_q <= 1'b0;
          cnt_q      <= LAT;
          state_q    <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (owner_q) begin
              ack1_q <= 1'b1;
              if (!wr_q) begin
                rdata1_q <= mem_q_i;
              end
            end else begin
              ack0_q <= 1'b1;
              if (!wr_q) begin
                rdata0_q <= mem_q_i;
              end
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack0_o     = ack0_q;
  assign ack1_o     = ack1_q;
  assign rdata0_o   = rdata0_q;
  assign rdata1_o   = rdata1_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_data_o = mem_data_q;
  assign mem_wren_o = mem_wren_q;
  assign busy_o     = busy_q;
  assign owner_o    = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios followed by randomized traffic,
// checked against a transaction-level model (grant order, completion time,
// reference memory contents). A second instance with read latency 3 runs a
// short directed check against a fixed-function memory.
module tb_dmem_arbiter;

  localparam int DW = 12;
  localparam int AW = 12;
  localparam int L  = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, mem_wren, busy, owner;
  logic [DW-1:0] rdata0, rdata1, mem_data, mem_q;
  logic [AW-1:0] mem_addr;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(L)) u_dut (
    .clk_i(clk), .reset_i(reset),
    .req0_i(req0), .req1_i(req1), .wr0_i(wr0), .wr1_i(wr1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .mem_addr_o(mem_addr), .mem_data_o(mem_data), .mem_wren_o(mem_wren),
    .mem_q_i(mem_q), .busy_o(busy), .owner_o(owner)
  );

  // Single-port memory, one-cycle registered read, plus a backdoor load port
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          bd_en;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  always @(posedge clk) begin
    if (bd_en) mem[bd_addr] <= bd_data;
    else if (mem_wren) mem[mem_addr] <= mem_data;
    mem_q <= mem[mem_addr];
  end

  // Latency-3 instance on its own memory: fixed contents, three read registers
  logic          d3_req;
  logic [AW-1:0] d3_addr;
  logic          d3_ack0, d3_ack1, d3_wren, d3_busy, d3_owner;
  logic [DW-1:0] d3_rdata0, d3_rdata1, d3_mdata, d3_q, d3_p0, d3_p1;
  logic [AW-1:0] d3_maddr;

  dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(3)) u_dut3 (
    .clk_i(clk), .reset_i(reset),
    .req0_i(d3_req), .req1_i(1'b0), .wr0_i(1'b0), .wr1_i(1'b0),
    .addr0_i(d3_addr), .addr1_i('0), .wdata0_i('0), .wdata1_i('0),
    .ack0_o(d3_ack0), .ack1_o(d3_ack1), .rdata0_o(d3_rdata0), .rdata1_o(d3_rdata1),
    .mem_addr_o(d3_maddr), .mem_data_o(d3_mdata), .mem_wren_o(d3_wren),
    .mem_q_i(d3_q), .busy_o(d3_busy), .owner_o(d3_owner)
  );

  function automatic logic [DW-1:0] rom3(input logic [AW-1:0] a);
    return a ^ 12'h5A5;
  endfunction

  always @(posedge clk) begin
    d3_p0 <= rom3(d3_maddr);
    d3_p1 <= d3_p0;
    d3_q  <= d3_p1;
  end

  // Reference model state
  int            vectors = 0;
  int            miscompares = 0;
  int            cyc = 0;
  int            m_done;
  bit            m_busy, m_own, m_wr, m_last;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data, m_rval;
  bit            e_ack0, e_ack1, e_wren;
  logic [DW-1:0] e_rd0, e_rd1;
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_wr = 0; m_last = 1;
    m_addr = '0; m_data = '0;
    e_ack0 = 0; e_ack1 = 0; e_wren = 0;
    e_rd0 = '0; e_rd1 = '0;
  endtask

  // One clock edge at transaction level: either complete the access in
  // flight when its time is up, or, if nothing is in flight, grant one.
  task automatic model_edge();
    bit p0, p1, win;
    p0 = req0 && !e_ack0;
    p1 = req1 && !e_ack1;
    e_ack0 = 0; e_ack1 = 0; e_wren = 0;
    cyc++;
    if (m_busy) begin
      if (cyc == m_done) begin
        m_busy = 0;
        if (m_own) e_ack1 = 1; else e_ack0 = 1;
        if (!m_wr) begin
          if (m_own) e_rd1 = m_rval; else e_rd0 = m_rval;
        end
      end
    end else if (p0 || p1) begin
      win    = (p0 && p1) ? !m_last : p1;
      m_last = win;
      m_own  = win;
      m_busy = 1;
      m_done = cyc + 1 + L;
      m_wr   = win ? wr1 : wr0;
      m_addr = win ? addr1 : addr0;
      m_data = win ? wdata1 : wdata0;
      e_wren = m_wr;
      if (m_wr) ref_mem[m_addr] = m_data;
      else      m_rval = ref_mem[m_addr];
    end
  endtask

  task automatic check_all();
    chk("ack0", 32'(ack0), 32'(e_ack0));
    chk("ack1", 32'(ack1), 32'(e_ack1));
    chk("rdata0", 32'(rdata0), 32'(e_rd0));
    chk("rdata1", 32'(rdata1), 32'(e_rd1));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("owner", 32'(owner), 32'(m_own));
    chk("mem_wren", 32'(mem_wren), 32'(e_wren));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("mem_data", 32'(mem_data), 32'(m_data));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Called at a falling edge; asserts reset mid-cycle and checks the async clear
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wren", 32'(mem_wren), 32'(0));
    chk("rst_owner", 32'(owner), 32'(0));
    chk("rst_rdata0", 32'(rdata0), 32'(0));
    model_reset();
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rst_ack0", 32'(ack0), 32'(0));
      chk("rst_ack1", 32'(ack1), 32'(0));
    end
    reset = 1'b0;
  endtask

  task automatic new_req(input bit p);
    logic          w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = 1'($urandom_range(1));
    a = AW'($urandom_range(15));
    d = DW'($urandom);
    if (p) begin req1 = 1'b1; wr1 = w; addr1 = a; wdata1 = d; end
    else   begin req0 = 1'b1; wr0 = w; addr0 = a; wdata0 = d; end
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    bd_en = 0; bd_addr = '0; bd_data = '0;
    d3_req = 0; d3_addr = '0;
    model_reset();

    // Preload addresses 0..15 while held in reset
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bd_en   = 1'b1;
      bd_addr = AW'(i);
      bd_data = (i == 5) ? 12'hABC : DW'(i * 37 + 256);
      ref_mem[i] = bd_data;
    end
    @(negedge clk);
    bd_en = 1'b0;
    check_all();
    chk("rst3_busy", 32'(d3_busy), 32'(0));
    chk("rst3_rdata", 32'(d3_rdata0), 32'(0));
    reset = 1'b0;

    // Port 0 read of address 5: ack in the third cycle
    req0 = 1; wr0 = 0; addr0 = 12'h005;
    step(); step(); step();
    chk("t1_ack0", 32'(ack0), 32'(1));
    chk("t1_rdata0", 32'(rdata0), 32'h0ABC);
    req0 = 0;
    step();

    // Port 1 write, then port 0 reads it back
    req1 = 1; wr1 = 1; addr1 = 12'h010; wdata1 = 12'h123;
    step();
    chk("t2_wren", 32'(mem_wren), 32'(1));
    chk("t2_addr", 32'(mem_addr), 32'h010);
    chk("t2_data", 32'(mem_data), 32'h123);
    step();
    chk("t2_wren_clr", 32'(mem_wren), 32'(0));
    step();
    chk("t2_ack1", 32'(ack1), 32'(1));
    req1 = 0;
    req0 = 1; wr0 = 0; addr0 = 12'h010;
    step();
    step(); step(); step();
    chk("t2_rdback", 32'(rdata0), 32'h123);
    req0 = 0;
    step();

    // Simultaneous requests after reset: port 0 first, then strict alternation
    do_reset();
    req0 = 1; wr0 = 0; addr0 = 12'h001;
    req1 = 1; wr1 = 0; addr1 = 12'h002;
    for (int t = 0; t < 4; t++) begin
      step(); step(); step();
      chk("alt_ack", 32'({ack1, ack0}), (t % 2 == 1) ? 32'h2 : 32'h1);
      if (t % 2 == 0) begin
        if (t < 2) addr0 = AW'(t + 3); else req0 = 0;
      end else begin
        if (t < 2) addr1 = AW'(t + 3); else req1 = 0;
      end
    end
    step();

    // Port 0 holds req through its ack: no grant in the ack cycle
    req0 = 1; wr0 = 0; addr0 = 12'h004;
    step(); step(); step();
    chk("hold_ack0", 32'(ack0), 32'(1));
    step();
    chk("hold_nogrant", 32'(busy), 32'(0));
    step();
    chk("hold_regrant", 32'(busy), 32'(1));
    step(); step();
    chk("hold_ack0b", 32'(ack0), 32'(1));
    req0 = 0;
    step();

    // Reset during ISSUE of a write: mem_wren drops at once
    req1 = 1; wr1 = 1; addr1 = 12'h3FF; wdata1 = 12'h777;
    step();
    chk("abort_w_wren", 32'(mem_wren), 32'(1));
    do_reset();

    // Reset during WAIT of a read: no ack ever; then a clean access
    req0 = 1; wr0 = 0; addr0 = 12'h006;
    step(); step();
    do_reset();
    step();
    req0 = 1; wr0 = 0; addr0 = 12'h007;
    step(); step(); step();
    chk("recover_ack0", 32'(ack0), 32'(1));
    chk("recover_rdata0", 32'(rdata0), 32'(ref_mem[7]));
    req0 = 0;
    step();

    // Latency-3 instance: ack in cycle 5, data from three cycles after ISSUE
    for (int k = 0; k < 2; k++) begin
      d3_addr = (k == 0) ? 12'h021 : 12'h0F0;
      d3_req  = 1'b1;
      for (int c = 1; c <= 5; c++) begin
        @(posedge clk);
        @(negedge clk);
        chk("l3_ack", 32'(d3_ack0), 32'(c == 5));
        chk("l3_busy", 32'(d3_busy), 32'(c != 5));
      end
      chk("l3_rdata", 32'(d3_rdata0), 32'(rom3(d3_addr)));
      d3_req = 1'b0;
      @(negedge clk);
    end

    // Randomized traffic on both ports
    for (int n = 0; n < 3000; n++) begin
      step();
      if (req0 && e_ack0) begin
        if ($urandom_range(1) == 1) new_req(1'b0); else req0 = 1'b0;
      end else if (!req0 && $urandom_range(2) == 0) begin
        new_req(1'b0);
      end
      if (req1 && e_ack1) begin
        if ($urandom_range(1) == 1) new_req(1'b1); else req1 = 1'b0;
      end else if (!req1 && $urandom_range(2) == 0) begin
        new_req(1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port round-robin arbiter that shares the single-port data memory between core1 and core2 of the dual-core processor. It sits between each core's address/data registers and the data memory, serialises their accesses, and returns read data and a completion pulse to each core. It drives the memory's address, data and write-enable, and compensates for the memory's registered read latency.

## Interface
- data_width, 12, width of memory words and core data
- addr_width, 12, data-memory address width
- read_latency, 1, cycles from memory capturing the address to valid memory output (1..7)

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request from core1 / core2
- wr0 / wr1  in  1  1 = write, 0 = read; held with req
- addr0 / addr1  in  addr_width  access address; held with req
- wdata0 / wdata1  in  data_width  write data; held with req
- ack0 / ack1  out  1  one-cycle completion pulse per transaction
- rdata0 / rdata1  out  data_width  read result, valid when ack is high, held until the next read completes on that port
- mem_addr  out  addr_width  to memory address
- mem_data  out  data_width  to memory data
- mem_wren  out  1  to memory write enable
- mem_q  in  data_width  memory read output
- busy  out  1  a transaction is in flight (state != IDLE)
- owner  out  1  port of the current or most recent grant

## Operation
- Requester rule: once reqN is high, the requester holds it, together with wrN, addrN and wdataN, stable until the cycle ackN is high. The requester drops reqN, or presents a new request, on the edge after ackN.
- States and transitions:
  - IDLE: arbitrates. A request causes the arbiter to register mem_addr, mem_data and owner, set mem_wren = wr of the winner, and move to ISSUE.
  - ISSUE: lasts one cycle. The memory captures the address. mem_wren clears at the end of ISSUE. A latency counter loads read_latency. The arbiter moves to WAIT.
  - WAIT: the counter decrements each cycle. On the edge where the counter equals 1, the arbiter pulses ackN for the owner, loads rdataN from mem_q for reads only, and returns to IDLE.
- Writes use the same WAIT duration as reads, giving uniform latency. rdataN is unchanged on writes.
- Arbitration:
  - A last_grant register resets to 1.
  - If only one unmasked request is present, that port wins.
  - If both are present, the port != last_grant wins.
  - last_grant updates on every grant.
- Masking: in IDLE, a port whose ackN is currently high is ignored that cycle. Its req is still up from the completed transaction and is not a new request.
- Once granted, a transaction always completes. Dropping req mid-transaction (an illegal requester action) does not abort it.
- mem_addr and mem_data hold their last values in IDLE. Only mem_wren gates writes.

## Timing
- Reset values:
  - ack0 = ack1 = 0
  - rdata0 = rdata1 = 0
  - mem_addr = 0, mem_data = 0, mem_wren = 0
  - busy = 0, owner = 0
  - state IDLE, last_grant = 1, counter 0
- Reset is asynchronous. Asserting it mid-transaction immediately clears mem_wren and busy, and no ack is ever issued for the aborted access.
- Latency: request sampled at edge E0, ISSUE during E0..E1, WAIT for read_latency cycles. ackN is high for exactly the one cycle after edge E(1+read_latency). With read_latency = 1, ack is high in the third cycle after the sampling edge.
- mem_wren is high for exactly one cycle per write, in ISSUE.
- Throughput: 2 + read_latency cycles per transaction. The ack cycle of one port may be the IDLE arbitration cycle for the other port (zero bubble).
- busy is high from ISSUE through the last WAIT cycle, and low during the ack cycle.

## Test plan
- After reset: all outputs 0. Read with req0, wr0 = 0, addr0 = 12'h005, memory holding 12'hABC at 5 -> ack0 is high in cycle 3, rdata0 = 12'hABC, mem_wren stays 0.
- Write with req1, addr1 = 12'h010, wdata1 = 12'h123 -> mem_wren = 1 for one cycle with mem_addr = 12'h010 and mem_data = 12'h123. A following read by port 0 at 12'h010 returns 12'h123.
- req0 and req1 asserted in the same cycle after reset -> port 0 granted first, port 1 granted in the cycle ack0 is high, ack1 follows 3 cycles later. Holding both requests continuously -> grants alternate 0, 1, 0, 1.
- Port 0 keeps req0 high through its ack cycle with port 1 idle -> no second grant is issued to port 0 in the ack cycle.
- reset asserted during WAIT of a read -> busy and mem_wren drop immediately, no ack pulse occurs. After release, a new request completes normally.
- read_latency = 3 -> ack is high in cycle 5 after the sampling edge, and rdata equals mem_q as presented 3 cycles after ISSUE.
